// File: rtl/board_char_scan_ctrl.sv
// board_char_scan_ctrl
// Walks every cell of the active board in raster order and drives the
// char_x/char_y lookup of the number-to-char converter. Each returned char_code
// is written to the character buffer after LAT cycles.
// Optional feature macro: BLANK_SKIP_EN (suppresses writes of zero codes).
module board_char_scan_ctrl #(
    parameter int LAT    = 1,   // converter latency, 1..4 cycles
    parameter int STRIDE = 16,  // character buffer row stride in cells
    parameter int ADDR_W = 8    // character buffer address width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        level,
    input  logic [5:0]        char_code,
    output logic [3:0]        char_x,
    output logic [3:0]        char_y,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [5:0]        wr_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(LAT - 1);

    state_t            state_q;
    logic [3:0]        x_q;
    logic [3:0]        y_q;
    logic [3:0]        last_q;      // N-1 of the board latched at start
    logic [3:0]        last_d;
    logic [2:0]        drain_q;
    logic              busy_q;
    logic              done_q;

    logic              push_valid_d;
    logic [ADDR_W-1:0] push_addr_d;
    logic              flush_d;
    logic              tail_valid;

    // Decode the board size (as N-1) from the requested level
    always_comb begin
        last_d = 4'd15;
        case (level)
            2'd1:    last_d = 4'd7;
            2'd2:    last_d = 4'd9;
            default: last_d = 4'd15;
        endcase
    end

    // Scan sequencer: raster walk, latency drain and one-cycle done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
            last_q  <= 4'd0;
            drain_q <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (level != 2'd0) begin
                            last_q  <= last_d;
                            x_q     <= 4'd0;
                            y_q     <= 4'd0;
                            busy_q  <= 1'b1;
                            state_q <= SCAN;
                        end else begin
                            // No board: complete immediately without writes
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                SCAN: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (x_q == last_q) begin
                        if (y_q == last_q) begin
                            // Final cell issued; coordinates hold on it
                            drain_q <= 3'd0;
                            state_q <= DRAIN;
                        end else begin
                            x_q <= 4'd0;
                            y_q <= y_q + 4'd1;
                        end
                    end else begin
                        x_q <= x_q + 4'd1;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (drain_q == DRAIN_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Every SCAN cycle issues one cell; abort discards everything in flight
    assign push_valid_d = (state_q == SCAN);
    assign push_addr_d  = ADDR_W'(STRIDE) * ADDR_W'(y_q) + ADDR_W'(x_q);
    assign flush_d      = abort && ((state_q == SCAN) || (state_q == DRAIN));

    // Delay line matching the converter latency: valid flag plus target address
    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_pipe
            logic              valid_q;
            logic [ADDR_W-1:0] addr_q;
            logic              valid_in;
            logic [ADDR_W-1:0] addr_in;

            if (gi == 0) begin : g_head
                assign valid_in = push_valid_d;
                assign addr_in  = push_addr_d;
            end else begin : g_tail
                assign valid_in = g_pipe[gi-1].valid_q;
                assign addr_in  = g_pipe[gi-1].addr_q;
            end

            // One latency stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    addr_q  <= '0;
                end else begin
                    valid_q <= valid_in && !flush_d;
                    addr_q  <= addr_in;
                end
            end
        end
    endgenerate

    assign tail_valid = g_pipe[LAT-1].valid_q;

    // The converter answer arrives in the same cycle the delayed cell emerges
`ifdef BLANK_SKIP_EN
    assign wr_en   = tail_valid && (char_code != 6'd0);
`else
    assign wr_en   = tail_valid;
`endif
    assign wr_addr = g_pipe[LAT-1].addr_q;
    assign wr_data = tail_valid ? char_code : 6'd0;

    assign char_x  = x_q;
    assign char_y  = y_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_board_char_scan_ctrl.sv
// Testbench for board_char_scan_ctrl: two instances (LAT=1 and LAT=2) share
// the control inputs; each has its own converter model with matching latency.
module tb_board_char_scan_ctrl;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        level = 2'd0;

    logic [5:0]        code1, code2;
    logic [3:0]        cx1, cy1, cx2, cy2;
    logic              busy1, done1, wr_en1, busy2, done2, wr_en2;
    logic [ADDR_W-1:0] wr_addr1, wr_addr2;
    logic [5:0]        wr_data1, wr_data2;

    board_char_scan_ctrl #(.LAT(1), .STRIDE(16), .ADDR_W(ADDR_W)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .level(level),
        .char_code(code1), .char_x(cx1), .char_y(cy1), .busy(busy1), .done(done1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1));

    board_char_scan_ctrl #(.LAT(2), .STRIDE(16), .ADDR_W(ADDR_W)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .level(level),
        .char_code(code2), .char_x(cx2), .char_y(cy2), .busy(busy2), .done(done2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Converter model: code = 48 + ((x+y) % 9), or all zero for a blank board
    bit zero_board = 1'b0;
    function automatic logic [5:0] conv(input logic [3:0] x, input logic [3:0] y);
        if (zero_board) return 6'd0;
        return 6'(48 + ((int'(x) + int'(y)) % 9));
    endfunction

    logic [5:0] h1 = 6'd0, h2a = 6'd0, h2b = 6'd0;
    always @(posedge clk) begin
        h1  <= conv(cx1, cy1);
        h2a <= conv(cx2, cy2);
        h2b <= h2a;
    end
    assign code1 = h1;
    assign code2 = h2b;

    // Monitor
    typedef struct {
        int c;
        int addr;
        int data;
    } wr_t;

    wr_t wq1[$], wq2[$];
    int  dq1[$], dq2[$];
    int  bcnt1, bcnt2, bfirst1, bfirst2;
    int  t0 = 0;

    always @(negedge clk) begin
        if (wr_en1) wq1.push_back('{cyc - t0, int'(wr_addr1), int'(wr_data1)});
        if (wr_en2) wq2.push_back('{cyc - t0, int'(wr_addr2), int'(wr_data2)});
        if (done1) dq1.push_back(cyc - t0);
        if (done2) dq2.push_back(cyc - t0);
        if (busy1) begin
            if (bfirst1 < 0) bfirst1 = cyc - t0;
            bcnt1++;
        end
        if (busy2) begin
            if (bfirst2 < 0) bfirst2 = cyc - t0;
            bcnt2++;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        wq1.delete(); wq2.delete(); dq1.delete(); dq2.delete();
        bcnt1 = 0; bcnt2 = 0; bfirst1 = -1; bfirst2 = -1;
    endtask

    task automatic begin_scan(input logic [1:0] lvl, input logic with_abort);
        @(negedge clk);
        level = lvl;
        start = 1'b1;
        abort = with_abort;
        t0    = cyc;
        clear_mon();
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while ((dq1.size() == 0 || dq2.size() == 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_dut(input string nm, input int lat, input int n, input int nwr,
                             input int last_addr, input int done_c, input wr_t q[$],
                             input int dq[$], input int bcnt, input int bfirst);
        int mism = 0;
        chk({nm, " writes"}, q.size(), nwr);
        chk({nm, " done_cnt"}, dq.size(), 1);
        if (dq.size() > 0) chk({nm, " done_cyc"}, dq[0], done_c);
        if (n > 0) begin
            chk({nm, " busy_cnt"}, bcnt, n * n + lat);
            chk({nm, " busy_first"}, bfirst, 1);
            for (int i = 0; i < q.size(); i++) begin
                int x = i % n;
                int y = i / n;
                int ed = zero_board ? 0 : 48 + ((x + y) % 9);
                if (q[i].addr != y * 16 + x || q[i].data != ed || q[i].c != i + 1 + lat) begin
                    if (mism == 0)
                        $display("  %s write %0d: cyc %0d addr %0d data %0d, want cyc %0d addr %0d data %0d",
                                 nm, i, q[i].c, q[i].addr, q[i].data, i + 1 + lat, y * 16 + x, ed);
                    mism++;
                end
            end
            chk({nm, " raster_mism"}, mism, 0);
            if (q.size() > 0 && nwr > 0) chk({nm, " last_addr"}, q[q.size()-1].addr, last_addr);
        end else begin
            chk({nm, " busy_cnt"}, bcnt, 0);
        end
    endtask

    typedef struct {
        logic [1:0] lvl;
        int         n;
        int         nwr;
        int         last;
        int         done1;
        int         done2;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int zexp;
        int cnt;
        int maxc;
        vecs[0] = '{2'd1, 8, 64, 119, 66, 67};
        vecs[1] = '{2'd2, 10, 100, 153, 102, 103};
        vecs[2] = '{2'd3, 16, 256, 255, 258, 259};
        vecs[3] = '{2'd0, 0, 0, -1, 1, 1};
        clear_mon();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset out1", int'(|{cx1, cy1, busy1, done1, wr_en1, wr_addr1, wr_data1}), 0);
        chk("reset out2", int'(|{cx2, cy2, busy2, done2, wr_en2, wr_addr2, wr_data2}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven full scans
        for (int i = 0; i < 4; i++) begin
            begin_scan(vecs[i].lvl, 1'b0);
            wait_done();
            $display("[TB] scan level %0d: lat1 %0d writes done@%0d, lat2 %0d writes done@%0d",
                     vecs[i].lvl, wq1.size(), (dq1.size() > 0) ? dq1[0] : -1,
                     wq2.size(), (dq2.size() > 0) ? dq2[0] : -1);
            check_dut($sformatf("L%0d lat1", vecs[i].lvl), 1, vecs[i].n, vecs[i].nwr,
                      vecs[i].last, vecs[i].done1, wq1, dq1, bcnt1, bfirst1);
            check_dut($sformatf("L%0d lat2", vecs[i].lvl), 2, vecs[i].n, vecs[i].nwr,
                      vecs[i].last, vecs[i].done2, wq2, dq2, bcnt2, bfirst2);
            if (vecs[i].lvl == 2'd1 && wq1.size() > 8) begin
                chk("L1 wr0 addr", wq1[0].addr, 0);
                chk("L1 wr8 addr", wq1[8].addr, 16);
            end
        end

        // start re-asserted mid-scan with a level change: ignored
        begin_scan(2'd2, 1'b0);
        repeat (10) @(negedge clk);
        level = 2'd3;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done();
        $display("[TB] restart-ignored: lat1 %0d writes, lat2 %0d writes", wq1.size(), wq2.size());
        check_dut("restart lat1", 1, 10, 100, 153, 102, wq1, dq1, bcnt1, bfirst1);
        check_dut("restart lat2", 2, 10, 100, 153, 103, wq2, dq2, bcnt2, bfirst2);

        // abort during SCAN cycle 20
        begin_scan(2'd1, 1'b0);
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy1 next", int'(busy1), 0);
        chk("abort busy2 next", int'(busy2), 0);
        repeat (30) @(negedge clk);
        $display("[TB] abort: lat1 %0d writes, lat2 %0d writes, dones %0d/%0d",
                 wq1.size(), wq2.size(), dq1.size(), dq2.size());
        cnt = wq1.size();
        chk("abort lat1 wr range", int'(cnt >= 19 && cnt <= 20), 1);
        cnt = wq2.size();
        chk("abort lat2 wr range", int'(cnt >= 18 && cnt <= 20), 1);
        maxc = 0;
        foreach (wq1[k]) if (wq1[k].c > maxc) maxc = wq1[k].c;
        chk("abort lat1 late wr", int'(maxc <= 21), 1);
        maxc = 0;
        foreach (wq2[k]) if (wq2[k].c > maxc) maxc = wq2[k].c;
        chk("abort lat2 late wr", int'(maxc <= 22), 1);
        chk("abort lat1 done", dq1.size(), 0);
        chk("abort lat2 done", dq2.size(), 0);

        // New start with abort in the same IDLE cycle: start wins
        begin_scan(2'd1, 1'b1);
        wait_done();
        $display("[TB] start+abort in IDLE: lat1 %0d writes, lat2 %0d writes", wq1.size(), wq2.size());
        check_dut("post-abort lat1", 1, 8, 64, 119, 66, wq1, dq1, bcnt1, bfirst1);
        check_dut("post-abort lat2", 2, 8, 64, 119, 67, wq2, dq2, bcnt2, bfirst2);

        // All-zero board at level 1
        zero_board = 1'b1;
`ifdef BLANK_SKIP_EN
        zexp = 0;
`else
        zexp = 64;
`endif
        begin_scan(2'd1, 1'b0);
        wait_done();
        $display("[TB] zero board: lat1 %0d writes, lat2 %0d writes", wq1.size(), wq2.size());
        check_dut("zero lat1", 1, 8, zexp, 119, 66, wq1, dq1, bcnt1, bfirst1);
        check_dut("zero lat2", 2, 8, zexp, 119, 67, wq2, dq2, bcnt2, bfirst2);
        zero_board = 1'b0;

        // Asynchronous reset in the middle of a level 3 scan
        begin_scan(2'd3, 1'b0);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid out1", int'(|{cx1, cy1, busy1, done1, wr_en1, wr_addr1, wr_data1}), 0);
        chk("rst_mid out2", int'(|{cx2, cy2, busy2, done2, wr_en2, wr_addr2, wr_data2}), 0);
        repeat (3) @(negedge clk);
        clear_mon();
        rst = 1'b0;
        repeat (300) @(negedge clk);
        $display("[TB] reset mid-scan: writes after reset %0d/%0d, dones %0d/%0d",
                 wq1.size(), wq2.size(), dq1.size(), dq2.size());
        chk("rst_mid lat1 writes", wq1.size(), 0);
        chk("rst_mid lat2 writes", wq2.size(), 0);
        chk("rst_mid lat1 done", dq1.size(), 0);
        chk("rst_mid lat2 done", dq2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
